// File: rtl/minmaxavg_sequencer_pkg.sv
// Shared definitions for the Min/Max/Avg statistics sequencer:
// state encoding, register initial values and divider length.
package minmaxavg_sequencer_pkg;

  localparam int DW_DEF     = 8;
  localparam int SW_DEF     = 16;
  localparam int CW_DEF     = 8;

  // Min starts at the most positive value, Max at the most negative,
  // so the first accepted sample always loads both registers.
  localparam int MIN_INIT   = 127;
  localparam int MAX_INIT   = -128;

  // One restoring-divide step per bit of the sum accumulator.
  localparam int DIV_CYCLES = SW_DEF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ACCUM = 3'd2,
    S_DIV   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/minmaxavg_sequencer_serial_divider.sv
// Serial restoring divider: unsigned SW-bit dividend by CW-bit divisor,
// one quotient bit per cycle. The first step runs in the start cycle, so
// the final quotient is presented (with done) in the SW-th cycle.
module minmaxavg_sequencer_serial_divider
  import minmaxavg_sequencer_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic [SW-1:0] quotient,
  output logic          done
);

  localparam int STEP_W = $clog2(SW);

  logic [SW-1:0]     quot_reg;
  logic [CW-1:0]     rem_reg;
  logic [STEP_W-1:0] step_reg;
  logic              running;

  logic [SW-1:0]     src_quot;
  logic [CW-1:0]     src_rem;
  logic [CW:0]       shifted;
  logic [CW:0]       rem_next;
  logic [SW-1:0]     quot_next;
  logic              unused_rem_msb;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    src_quot  = start ? dividend : quot_reg;
    src_rem   = start ? '0 : rem_reg;
    shifted   = {src_rem, src_quot[SW-1]};
    rem_next  = shifted;
    quot_next = {src_quot[SW-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_next     = shifted - {1'b0, divisor};
      quot_next[0] = 1'b1;
    end
  end

  // The remainder is always below the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem_next[CW];

  assign done     = running && (step_reg == STEP_W'(SW - 1));
  assign quotient = quot_next;

  // Iteration state: partial quotient, remainder and step counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      quot_reg <= '0;
      rem_reg  <= '0;
      step_reg <= '0;
      running  <= 1'b0;
    end else if (start || running) begin
      quot_reg <= quot_next;
      rem_reg  <= rem_next[CW-1:0];
      step_reg <= start ? STEP_W'(1) : step_reg + STEP_W'(1);
      running  <= start ? 1'b1 : !done;
    end
  end

endmodule

// File: rtl/minmaxavg_sequencer.sv
// Sequencer for one Min/Max/Avg statistics run: initialises the external
// Min/Max registers, strobes them on new extremes, accumulates the sum and
// divides it by the sample count (truncating toward zero).
module minmaxavg_sequencer
  import minmaxavg_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  input  logic [DW-1:0] min_q,
  input  logic [DW-1:0] max_q,
  output logic [DW-1:0] min_d,
  output logic          min_load,
  output logic [DW-1:0] max_d,
  output logic          max_load,
  output logic [DW-1:0] avg_out,
  output logic          busy,
  output logic          done,
  output logic          empty
);

  state_t        state, state_next;
  logic [CW-1:0] remaining;
  logic [CW-1:0] divisor;
  logic [SW-1:0] sum;
  logic          div_start;
  logic          div_done;
  logic [SW-1:0] div_q;
  logic          accept;
  logic          sum_neg;
  logic [SW-1:0] sum_mag;
  logic [DW-1:0] avg_next;
  logic          unused_quot_bits;

  assign accept  = (state == S_ACCUM) && sample_valid;
  assign sum_neg = sum[SW-1];
  assign sum_mag = sum_neg ? (SW'(0) - sum) : sum;

  // The magnitude quotient always fits DW, so negating just the low bits
  // gives the correctly signed, zero-truncated average.
  assign avg_next         = sum_neg ? (DW'(0) - div_q[DW-1:0]) : div_q[DW-1:0];
  assign unused_quot_bits = ^div_q[SW-1:DW];

  minmaxavg_sequencer_serial_divider #(.SW(SW), .CW(CW)) u_divider (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (div_start),
    .dividend (sum_mag),
    .divisor  (divisor),
    .quotient (div_q),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_INIT;
      S_INIT:  state_next = (remaining == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (accept && remaining == CW'(1)) state_next = S_DIV;
      S_DIV:   if (div_done) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Register-side strobes and handshake; compares use the registers as presented.
  always_comb begin
    sample_ready = 1'b0;
    min_d        = '0;
    max_d        = '0;
    min_load     = 1'b0;
    max_load     = 1'b0;
    case (state)
      S_INIT: begin
        min_d    = DW'(MIN_INIT);
        max_d    = DW'(MAX_INIT);
        min_load = 1'b1;
        max_load = 1'b1;
      end
      S_ACCUM: begin
        sample_ready = 1'b1;
        if (accept) begin
          min_d    = sample_in;
          max_d    = sample_in;
          min_load = $signed(sample_in) < $signed(min_q);
          max_load = $signed(sample_in) > $signed(max_q);
        end
      end
      default: ;
    endcase
  end

  // Run datapath: count latch, sum accumulation, divider kick-off and status flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      remaining <= '0;
      divisor   <= '0;
      sum       <= '0;
      div_start <= 1'b0;
      avg_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      empty     <= 1'b0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= count;
            divisor   <= count;
            busy      <= 1'b1;
          end
        end
        S_INIT: begin
          sum     <= '0;
          empty   <= (remaining == '0);
          avg_out <= '0;
          if (remaining == '0) done <= 1'b1;
        end
        S_ACCUM: begin
          if (accept) begin
            sum       <= sum + {{(SW-DW){sample_in[DW-1]}}, sample_in};
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) div_start <= 1'b1;
          end
        end
        S_DIV: begin
          if (div_done) begin
            avg_out <= avg_next;
            done    <= 1'b1;
          end
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/minmaxavg_sequencer.md
Name: minmaxavg_sequencer

Overview:
Controller that sequences the 8-bit signed Max/Min/Avg datapath for one statistics run over N streamed samples. It initialises the external Min and Max registers, compares each accepted sample against their current outputs and drives their load strobes. It also accumulates a running sum and computes the average with a serial divider. It sits between the sample source (valid/ready) and the Min/Max register pair, and is started by the instruction decoder.

Parameters:
DW, 8, sample / register width (signed two's complement)
SW, 16, sum accumulator width (holds 255 x -128 without overflow)
CW, 8, sample-count width

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
count  in  CW  number of samples; latched on accepted start
sample_in  in  DW  signed sample
sample_valid  in  1  sample_in is valid
sample_ready  out  1  sequencer accepts a sample this cycle
min_q  in  DW  current Min register output
max_q  in  DW  current Max register output
min_d  out  DW  data to Min register
min_load  out  1  Min register load strobe
max_d  out  DW  data to Max register
max_load  out  1  Max register load strobe
avg_out  out  DW  signed average, held until the next run's INIT
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
empty  out  1  last run had count==0

Behaviour:
- Reset (async, RESET=0): state=IDLE; busy=0, done=0, empty=0, avg_out=0, sum=0, remaining=0. Combinational outputs take their IDLE values: sample_ready=0, min_load=0, max_load=0, min_d=0, max_d=0.
- A reset mid-run aborts the run with no done pulse. The external registers share RESET.
- States: IDLE, INIT, ACCUM, DIV, DONE.
- IDLE:
  - start=1 latches count into remaining and moves to INIT.
  - busy rises on the same edge.
  - start in any other state is ignored.
- INIT (1 cycle):
  - min_d=127, max_d=-128, min_load=max_load=1.
  - sum<=0; empty<=(remaining==0); avg_out<=0.
  - Next state is DONE if remaining==0, else ACCUM.
- ACCUM:
  - sample_ready=1.
  - A sample is accepted on sample_valid & sample_ready.
  - On accept:
    - sum<=sum+sign-extended sample.
    - min_d=max_d=sample_in.
    - min_load=(sample_in<min_q), signed compare. max_load=(sample_in>max_q), signed compare.
    - remaining<=remaining-1. If remaining==1, next state is DIV.
  - Comparisons use min_q/max_q as presented; the registers update on the load edge, so back-to-back samples are correct with no stall.
  - Equal values do not load.
  - sample_valid=0 holds state with no strobes.
- DIV:
  - Serial restoring divide of |sum| by the latched count, SW cycles, exactly 16.
  - Quotient sign is negated if sum<0, so the result truncates toward zero.
  - The result always fits DW. On the final cycle avg_out<=quotient[DW-1:0].
- DONE (1 cycle): done=1, then IDLE with busy=0. avg_out and empty hold.
- Latency, start to done: 1 (INIT) + cycles to accept N samples + 16 (DIV) + 1 (DONE). With sample_valid held high and N=4, done is asserted 22 cycles after the start edge.
- The latched count is not affected by changes on the count input during a run.

Decomposition:
- Shared package: state encoding, MIN_INIT=127, MAX_INIT=-128, DIV_CYCLES=SW.
- One sub-module, serial_divider: start, SW-bit dividend magnitude, CW-bit divisor, SW-cycle restoring loop, quotient and done outputs.
- Sign handling and truncation stay in the sequencer.

Test Plan:
- count=4, samples 10,-20,30,5 continuous -> min_load on 10 and -20; max_load on 10 and 30; final min_q=-20, max_q=30, avg_out=6 (25/4); done 22 cycles after start.
- count=0 -> INIT loads 127/-128 into the registers; done 2 cycles after start; empty=1; avg_out=0; sample_ready never asserted.
- count=3, samples -128,-128,-127 -> min_q=-128, max_q=-127, avg_out=-127 (-383/3 truncated toward zero); second -128 produces no min_load.
- count=255, all samples 127 -> avg_out=127, sum=32385. Repeat with all samples -128 -> avg_out=-128. No overflow in either case.
- sample_valid toggling every other cycle, plus start pulsed while busy -> strobes only on accept cycles; extra start ignored; a single done pulse.
- RESET pulled low in ACCUM after 2 of 5 samples -> busy, sample_ready, min_load, max_load and avg_out all 0 immediately; a subsequent start with count=1, sample 7 -> avg_out=7.
